// File: rtl/mem_if_pkg.sv
// Shared encodings for the memory bus master: command, access size and FSM state.
package mem_if_pkg;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } cmd_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_BAD  = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_RDAT = 3'd2,
        S_WDAT = 3'd3,
        S_RESP = 3'd4
    } state_e;

    // Natural alignment: halves on even bytes, words on word boundaries.
    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] offset);
        case (size_e'(size))
            SIZE_BYTE: is_legal = 1'b1;
            SIZE_HALF: is_legal = ~offset[0];
            SIZE_WORD: is_legal = (offset == 2'b00);
            default:   is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_data_align.sv
// Byte-lane steering for a 32-bit bus: write strobes, write-data replication,
// and read-data right-justification with sign or zero extension.
module mem_data_align
    import mem_if_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  strb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata_raw >> {offset, 3'b000};
        strb      = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = shifted;
        case (size_e'(size))
            SIZE_BYTE: begin
                strb      = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'd0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                strb      = 4'b0011 << offset;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = is_unsigned ? {16'd0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_bus_master.sv
// Single-outstanding memory bus master: turns byte/half/word requests into
// command, read-data and write-data channel transfers with one response each.
module mem_bus_master
    import mem_if_pkg::*;
#(
    parameter int p_ADDR_BITS = 32,
    parameter int p_DATA_BITS = 32,
    parameter int p_STRB_BITS = p_DATA_BITS / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_cmd,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [p_ADDR_BITS-1:0] req_addr,
    input  logic [p_DATA_BITS-1:0] req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [p_DATA_BITS-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic [p_ADDR_BITS-1:0] mem_addr,
    output logic                   mem_cmd,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    input  logic                   mem_r_valid,
    input  logic [p_DATA_BITS-1:0] mem_r_data,
    input  logic                   mem_r_resp,
    output logic                   mem_r_ready,
    output logic                   mem_w_valid,
    output logic [p_STRB_BITS-1:0] mem_w_strb,
    output logic [p_DATA_BITS-1:0] mem_w_data,
    input  logic                   mem_w_ready,
    input  logic                   mem_w_resp,
    output state_e                 dbg_state
);

    // Every channel transfers on the rising edge where valid && ready; a
    // valid, once raised, holds itself and its payload until that edge.

    state_e                 state_q, state_d;
    logic                   cmd_q;
    logic [1:0]             size_q;
    logic                   uns_q;
    logic [p_ADDR_BITS-1:0] addr_q;
    logic [p_DATA_BITS-1:0] wdata_q;
    logic [p_DATA_BITS-1:0] rdata_q;
    logic                   err_q;
    logic                   legal;
    logic [3:0]             strb;
    logic [31:0]            wdata_rep;
    logic [31:0]            rdata_ext;

    assign legal     = is_legal(req_size, req_addr[1:0]);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign dbg_state = state_q;

    mem_data_align u_align (
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata_raw   (mem_r_data),
        .strb        (strb),
        .wdata_rep   (wdata_rep),
        .rdata_ext   (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Bus outputs decode straight from state so reset drops them immediately.
    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        mem_valid   = 1'b0;
        mem_addr    = '0;
        mem_cmd     = 1'b0;
        mem_r_ready = 1'b0;
        mem_w_valid = 1'b0;
        mem_w_strb  = '0;
        mem_w_data  = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = rst;
                if (req_valid) state_d = legal ? S_CMD : S_RESP;
            end
            S_CMD: begin
                mem_valid = 1'b1;
                mem_addr  = {addr_q[p_ADDR_BITS-1:2], 2'b00};
                mem_cmd   = cmd_q;
                if (mem_ready) state_d = (cmd_q == CMD_WRITE) ? S_WDAT : S_RDAT;
            end
            S_RDAT: begin
                mem_r_ready = 1'b1;
                if (mem_r_valid) state_d = S_RESP;
            end
            S_WDAT: begin
                mem_w_valid = 1'b1;
                mem_w_strb  = strb;
                mem_w_data  = wdata_rep;
                if (mem_w_ready) state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q   <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        cmd_q   <= req_cmd;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= ~legal;
                    end
                end
                S_RDAT: begin
                    if (mem_r_valid) begin
                        rdata_q <= rdata_ext;
                        err_q   <= mem_r_resp;
                    end
                end
                S_WDAT: begin
                    if (mem_w_ready) begin
                        rdata_q <= '0;
                        err_q   <= mem_w_resp;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 The block SHALL have parameter p_ADDR_BITS, default 32, bus address width in bits.
REQ-002 The block SHALL have parameter p_DATA_BITS, default 32, bus data width in bits; only 32 is supported.
REQ-003 The block SHALL have parameter p_STRB_BITS, default p_DATA_BITS/8, number of write-strobe bits.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  upstream request valid.
REQ-007 req_ready  out  1  upstream request accepted when high with req_valid.
REQ-008 req_cmd  in  1  0 = read, 1 = write.
REQ-009 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-010 req_unsigned  in  1  read zero-extend when 1, sign-extend when 0.
REQ-011 req_addr  in  p_ADDR_BITS  byte address.
REQ-012 req_wdata  in  p_DATA_BITS  write data, LSB-justified.
REQ-013 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-014 rsp_rdata / rsp_err  out / out  p_DATA_BITS / 1  extended read data; error flag.
REQ-015 mem_addr, mem_cmd, mem_valid  out  p_ADDR_BITS, 1, 1  command channel.
REQ-016 mem_ready  in  1  command accepted.
REQ-017 mem_r_valid, mem_r_data, mem_r_resp  in  1, p_DATA_BITS, 1  read channel; resp 1 = error.
REQ-018 mem_r_ready  out  1  read data accepted.
REQ-019 mem_w_valid, mem_w_strb, mem_w_data  out  1, p_STRB_BITS, p_DATA_BITS  write channel.
REQ-020 mem_w_ready, mem_w_resp  in  1, 1  write accepted; resp 1 = error, sampled with mem_w_ready.

Function
REQ-021 The FSM SHALL have states IDLE, CMD, RDAT, WDAT, RESP; one transaction outstanding.
REQ-022 req_ready SHALL be 1 only in IDLE; request captured into registers on req_valid && req_ready.
REQ-023 From IDLE, a legal, aligned request SHALL go to CMD; a misaligned one (half with addr[0]=1, word with addr[1:0]!=0) or req_size=3 SHALL go to RESP with rsp_err=1, rsp_rdata=0, no bus activity.
REQ-024 In CMD: mem_valid=1 and mem_addr={addr[p_ADDR_BITS-1:2],2'b00}, both held stable until mem_ready; then next state is RDAT (read) or WDAT (write).
REQ-025 In RDAT: mem_r_ready=1; on mem_r_valid, capture the aligned, extended data and mem_r_resp as rsp_err, then go to RESP.
REQ-026 In WDAT: mem_w_valid=1, held stable with strb/data until mem_w_ready; capture mem_w_resp as rsp_err, rsp_rdata=0, then go to RESP.
REQ-027 Strobes SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-028 Write data SHALL be replicated: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-029 Read data SHALL be shifted right by 8*addr[1:0], then for byte/half sign- or zero-extended per req_unsigned.
REQ-030 In RESP: rsp_valid=1 until rsp_ready, then go to IDLE; rsp_rdata and rsp_err stay stable while waiting.
REQ-031 mem_r_valid outside RDAT and mem_w_ready outside WDAT SHALL be ignored.
REQ-032 Minimum latency: accept at cycle 0, mem_valid at cycle 1, mem_r_valid at cycle 2, rsp_valid at cycle 3.

Reset
REQ-033 While rst=0, the FSM SHALL be in IDLE and every output SHALL be 0 except req_ready=1 once rst deasserts; all capture registers SHALL clear.
REQ-034 Reset mid-transaction SHALL abandon it with no response; mem_valid, mem_r_ready and mem_w_valid SHALL drop asynchronously.

Structure
REQ-035 Package mem_if_pkg SHALL hold the cmd encodings (READ=0, WRITE=1), the size encodings and the FSM state enum.
REQ-036 Byte-lane alignment and extension (REQ-027 to REQ-029) SHALL live in one combinational sub-module, mem_data_align.

Verification
REQ-037 Word read of addr 0x100; memory returns 0xDEADBEEF after 2 wait cycles -> mem_addr=0x100, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-038 Signed byte read of addr 0x103, memory word 0x80112233 -> rsp_rdata=0xFFFFFF80; the same read with req_unsigned=1 -> rsp_rdata=0x00000080.
REQ-039 Half write of 0x0000ABCD to addr 0x202 -> mem_addr=0x200, mem_w_strb=4'b1100, mem_w_data=0xABCDABCD, rsp_err=0.
REQ-040 Word read of addr 0x101 -> mem_valid never asserts, rsp_valid one cycle after accept, rsp_err=1.
REQ-041 mem_ready withheld 5 cycles with rsp_ready low 3 cycles -> mem_addr and rsp_rdata stable throughout; mem_r_resp=1 -> rsp_err=1.
REQ-042 rst asserted while in WDAT -> mem_w_valid=0 immediately; after release req_ready=1 and no response is issued.
